polyshift_pipe: RTL and testbench
=================================

// Module: polyshift_pipe
// PURPOSE
//  Pipelined, handshaked bidirectional funnel shifter: left/right, LOGIC/ARITHMETIC/DOUBLE_PRECISION/CYCLIC.
//  Successor to the combinational left-only shifter: adds direction, full-width fill word, carry/zero flags.
//  Also adds configurable pipeline registers and valid/ready flow control.
//  Sits between the ALU operand mux and the result writeback.
// PARAMETERS
//  WORD_WIDTH  32  operand/result width; power of two, >= 4; L = $clog2(WORD_WIDTH)
//  STAGE_MASK  '0  [L-1:0]; bit k = 1 puts a register after funnel stage k (shift by 2**k)
// PORTS
//  clk_i          in   1           clock
//  rst_ni         in   1           reset: asynchronous assert, active-low
//  flush_i        in   1           synchronous discard of every in-flight operation
//  valid_i        in   1           input operation valid
//  ready_o        out  1           input slot can accept
//  d_i            in   WORD_WIDTH  word to shift
//  c_i            in   WORD_WIDTH  fill word (DOUBLE_PRECISION only)
//  shift_size_i   in   L           shift amount 0..WORD_WIDTH-1
//  shift_type_i   in   2           polyshift_pkg::shift_type_t
//  dir_i          in   1           0 = left, 1 = right
//  valid_o        out  1           result valid
//  ready_i        in   1           consumer accepts result
//  d_o            out  WORD_WIDTH  shifted word
//  carry_o        out  1           last bit shifted out
//  zero_o         out  1           d_o == 0
// BEHAVIOUR
//  Fill word F is chosen per type:
//    LOGIC: 0.  ARITHMETIC: left 0, right {W{d_i[W-1]}}.  DOUBLE_PRECISION: c_i.  CYCLIC: d_i.
//  Result, n = shift_size_i:
//    left:  d_o = ({d_i,F} << n)[2W-1:W].  right: d_o = ({F,d_i} >> n)[W-1:0].
//  carry: n==0 -> 0; left -> d_i[W-n]; right -> d_i[n-1]. zero_o computed from final result.
//  Funnel built as L log stages on a 2W word; direction, n, and the flags travel with the data.
//  Latency = 1 + popcount(STAGE_MASK) cycles. Output register always present.
//  No combinational path from valid_i/d_i to any output.
//  Handshake, per slot s:
//    - Slot advances when it is empty OR the next slot advances. Output slot advances on ~valid_o | ready_i.
//    - ready_o = input slot advances (comb. ready_i->ready_o chain allowed). Transfer = valid_i & ready_o.
//    - Full throughput: one op/cycle while ready_i stays high.
//  Stall: while valid_o & ~ready_i, d_o/carry_o/zero_o are held stable. Order preserved, no drop, no duplication.
//  flush_i: at the next edge all slot valids clear. Data regs don't care.
//    An op transferred in the flush cycle is discarded. ready_o is unaffected by flush_i.
//  Reset (rst_ni low, any time incl. mid-operation): all valids 0, d_o 0, carry_o 0, zero_o 0, immediately.
//    valid_o rises no earlier than latency cycles after the first transfer following reset release.
//  shift_size_i == 0: d_o = d_i for every type and direction.
//  Flags are meaningful only while valid_o = 1.
// STRUCTURE
//  Package polyshift_pkg:
//    shift_type_t enum {LOGIC=0, ARITHMETIC=1, DOUBLE_PRECISION=2, CYCLIC=3}
//    dir_t enum {DIR_LEFT=0, DIR_RIGHT=1}
//    stage payload struct type, parameterised through the width localparams
//  Sub-module polyshift_funnel_stage:
//    one 2W-bit stage, conditional shift by 2**k, optional register + valid/ready slot.
//    Instantiated L times via generate with STAGE_MASK[k].
//  Top: fill select, carry compute, output register, zero flag.
// TESTING (W=8, STAGE_MASK=3'b010, latency 2)
//  1. LOGIC left, d=0xB5, n=3 -> d_o=0xA8, carry=1, zero=0, valid_o exactly 2 cycles after transfer.
//  2. ARITHMETIC right, d=0x96, n=2 -> 0xE5, carry=1. CYCLIC right, d=0x81, n=1 -> 0xC0, carry=1.
//  3. DOUBLE_PRECISION left, d=0x0F, c=0xA0, n=4 -> 0xFA, carry=0. LOGIC left, d=0x80, n=1 -> 0x00, zero=1, carry=1.
//  4. Back-to-back 6 ops, ready_i low 5 cycles mid-stream:
//     ready_o falls once 2 ops are held, d_o stable while stalled, all 6 results in order, no gaps after release.
//  5. n=0 sweep over all 4 types x both dirs, d=0x5A -> d_o=0x5A, carry=0.
//  6. rst_ni low async with 2 in flight -> valid_o=0, d_o=0 before next edge.
//     Same scenario with flush_i -> valid_o=0 after edge. Transfer in the flush cycle never appears.
//  Scoreboard: random types/dirs/sizes vs reference model, random ready_i, 10k ops, zero mismatches.

Source files
------------

// File: rtl/polyshift_pkg.sv
// polyshift_pkg
//   Shared types for the polyshift funnel shifter pipeline.
//   shift_type_t : fill-word selection (LOGIC, ARITHMETIC, DOUBLE_PRECISION, CYCLIC)
//   dir_t        : shift direction (DIR_LEFT, DIR_RIGHT)
//   stage_meta_t : width-independent part of the payload that travels with the
//                  data through every funnel stage; the 2W data word and the
//                  shift amount are carried as vectors sized by the module width.
package polyshift_pkg;

  localparam int unsigned SHIFT_TYPE_W = 2;

  typedef enum logic [SHIFT_TYPE_W-1:0] {
    LOGIC            = 2'd0,
    ARITHMETIC       = 2'd1,
    DOUBLE_PRECISION = 2'd2,
    CYCLIC           = 2'd3
  } shift_type_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  typedef struct packed {
    dir_t dir;
    logic carry;
  } stage_meta_t;

endpackage

// File: rtl/polyshift_funnel_stage.sv
// polyshift_funnel_stage
//   One log stage of the funnel: conditionally shifts the 2W word by 2**STAGE_IDX
//   in the direction carried in the payload, then optionally registers the
//   result in a valid/ready slot.
// Ports
//   clk_i, rst_ni, flush_i : clock, async active-low reset, sync flush
//   valid_i/ready_o        : upstream handshake
//   data_i, amt_i, meta_i  : 2W funnel word, shift amount, travelling metadata
//   valid_o/ready_i        : downstream handshake
//   data_o, amt_o, meta_o  : payload after this stage
module polyshift_funnel_stage
  import polyshift_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned STAGE_IDX  = 0,
  parameter bit          REGISTERED = 1'b0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [2*WORD_WIDTH-1:0]        data_i,
  input  logic [$clog2(WORD_WIDTH)-1:0]  amt_i,
  input  stage_meta_t                    meta_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [2*WORD_WIDTH-1:0]        data_o,
  output logic [$clog2(WORD_WIDTH)-1:0]  amt_o,
  output stage_meta_t                    meta_o
);

  localparam int unsigned SH = 1 << STAGE_IDX;

  logic [2*WORD_WIDTH-1:0] shifted;

  always_comb begin
    shifted = data_i;
    if (amt_i[STAGE_IDX]) begin
      shifted = (meta_i.dir == DIR_RIGHT) ? (data_i >> SH) : (data_i << SH);
    end
  end

  if (REGISTERED) begin : g_reg
    logic                          slot_valid;
    logic [2*WORD_WIDTH-1:0]       slot_data;
    logic [$clog2(WORD_WIDTH)-1:0] slot_amt;
    stage_meta_t                   slot_meta;
    logic                          advance;

    // The slot may take a new entry when empty or when its occupant moves on;
    // flush only clears the valid, so ready is unaffected by it.
    assign advance = ~slot_valid | ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        slot_valid <= 1'b0;
        slot_data  <= '0;
        slot_amt   <= '0;
        slot_meta  <= '0;
      end else begin
        if (flush_i) begin
          slot_valid <= 1'b0;
        end else if (advance) begin
          slot_valid <= valid_i;
        end
        if (advance && valid_i) begin
          slot_data <= shifted;
          slot_amt  <= amt_i;
          slot_meta <= meta_i;
        end
      end
    end

    assign ready_o = advance;
    assign valid_o = slot_valid;
    assign data_o  = slot_data;
    assign amt_o   = slot_amt;
    assign meta_o  = slot_meta;
  end else begin : g_comb
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, flush_i};

    assign ready_o = ready_i;
    assign valid_o = valid_i;
    assign data_o  = shifted;
    assign amt_o   = amt_i;
    assign meta_o  = meta_i;
  end

endmodule

// File: rtl/polyshift_pipe.sv
// polyshift_pipe
//   Pipelined valid/ready bidirectional funnel shifter with LOGIC, ARITHMETIC,
//   DOUBLE_PRECISION and CYCLIC fill modes, plus carry and zero flags.
//   Latency is 1 + popcount(STAGE_MASK); the output register is always present.
// Ports
//   clk_i, rst_ni, flush_i     : clock, async active-low reset, sync flush
//   valid_i/ready_o            : operation handshake
//   d_i, c_i                   : word to shift, fill word for DOUBLE_PRECISION
//   shift_size_i, shift_type_i : shift amount, shift_type_t
//   dir_i                      : 0 left, 1 right
//   valid_o/ready_i            : result handshake
//   d_o, carry_o, zero_o       : result, last bit shifted out, result is zero
module polyshift_pipe
  import polyshift_pkg::*;
#(
  parameter int unsigned                    WORD_WIDTH = 32,
  parameter logic [$clog2(WORD_WIDTH)-1:0]  STAGE_MASK = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [WORD_WIDTH-1:0]          d_i,
  input  logic [WORD_WIDTH-1:0]          c_i,
  input  logic [$clog2(WORD_WIDTH)-1:0]  shift_size_i,
  input  logic [1:0]                     shift_type_i,
  input  logic                           dir_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [WORD_WIDTH-1:0]          d_o,
  output logic                           carry_o,
  output logic                           zero_o
);

  localparam int unsigned L = $clog2(WORD_WIDTH);

  shift_type_t             shift_type;
  dir_t                    dir;
  logic [WORD_WIDTH-1:0]   fill;
  logic                    carry_in;
  logic [L-1:0]            idx_left;
  logic [L-1:0]            idx_right;

  assign shift_type = shift_type_t'(shift_type_i);
  assign dir        = dir_t'(dir_i);

  always_comb begin
    fill = '0;
    case (shift_type)
      LOGIC:            fill = '0;
      ARITHMETIC:       fill = (dir == DIR_RIGHT) ? {WORD_WIDTH{d_i[WORD_WIDTH-1]}} : '0;
      DOUBLE_PRECISION: fill = c_i;
      CYCLIC:           fill = d_i;
      default:          fill = '0;
    endcase
  end

  // W is a power of two, so W-n wraps cleanly to 0-n in L bits for n >= 1.
  assign idx_left  = L'(0) - shift_size_i;
  assign idx_right = shift_size_i - L'(1);

  always_comb begin
    carry_in = 1'b0;
    if (shift_size_i != '0) begin
      carry_in = (dir == DIR_RIGHT) ? d_i[idx_right] : d_i[idx_left];
    end
  end

  logic [2*WORD_WIDTH-1:0] st_data  [0:L];
  logic [L-1:0]            st_amt   [0:L];
  stage_meta_t             st_meta  [0:L];
  logic                    st_valid [0:L];
  logic                    st_ready [0:L];

  // Left shifts take the upper half of {d,F}; right shifts the lower half of {F,d}.
  assign st_data[0]  = (dir == DIR_RIGHT) ? {fill, d_i} : {d_i, fill};
  assign st_amt[0]   = shift_size_i;
  assign st_meta[0]  = '{dir: dir, carry: carry_in};
  assign st_valid[0] = valid_i;
  assign ready_o     = st_ready[0];

  for (genvar k = 0; k < L; k++) begin : g_stage
    polyshift_funnel_stage #(
      .WORD_WIDTH (WORD_WIDTH),
      .STAGE_IDX  (k),
      .REGISTERED (STAGE_MASK[k])
    ) u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .valid_i (st_valid[k]),
      .ready_o (st_ready[k]),
      .data_i  (st_data[k]),
      .amt_i   (st_amt[k]),
      .meta_i  (st_meta[k]),
      .valid_o (st_valid[k+1]),
      .ready_i (st_ready[k+1]),
      .data_o  (st_data[k+1]),
      .amt_o   (st_amt[k+1]),
      .meta_o  (st_meta[k+1])
    );
  end

  logic unused_amt;
  assign unused_amt = ^st_amt[L];

  logic [WORD_WIDTH-1:0] result;
  logic                  out_advance;

  assign result      = (st_meta[L].dir == DIR_RIGHT) ? st_data[L][WORD_WIDTH-1:0]
                                                     : st_data[L][2*WORD_WIDTH-1:WORD_WIDTH];
  assign out_advance = ~valid_o | ready_i;
  assign st_ready[L] = out_advance;

  // Output slot: result and flags only load with a valid entry, so they stay
  // stable for the whole time a result is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      d_o     <= '0;
      carry_o <= 1'b0;
      zero_o  <= 1'b0;
    end else begin
      if (flush_i) begin
        valid_o <= 1'b0;
      end else if (out_advance) begin
        valid_o <= st_valid[L];
      end
      if (out_advance && st_valid[L]) begin
        d_o     <= result;
        carry_o <= st_meta[L].carry;
        zero_o  <= (result == '0);
      end
    end
  end

endmodule

// File: tb/tb_polyshift_pipe.sv
// tb_polyshift_pipe
//   Bench for polyshift_pipe at W=8, STAGE_MASK=3'b010 (latency 2).
//   A behavioural model fills a scoreboard queue at every accepted transfer and
//   one compare process checks every valid output cycle against its head.
module tb_polyshift_pipe;
  import polyshift_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       flush_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] d_i;
  logic [7:0] c_i;
  logic [2:0] shift_size_i;
  logic [1:0] shift_type_i;
  logic       dir_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] d_o;
  logic       carry_o;
  logic       zero_o;

  polyshift_pipe #(
    .WORD_WIDTH (8),
    .STAGE_MASK (3'b010)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .d_i          (d_i),
    .c_i          (c_i),
    .shift_size_i (shift_size_i),
    .shift_type_i (shift_type_i),
    .dir_i        (dir_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .d_o          (d_o),
    .carry_o      (carry_o),
    .zero_o       (zero_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] d;
    logic       carry;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference: the result is the window of the 2W funnel word; the carry is
  // simply the last bit that fell off the end, taken from one extra bit.
  function automatic exp_t model(input logic [7:0] d, input logic [7:0] c,
                                 input logic [2:0] n, input logic [1:0] t,
                                 input logic dr);
    logic [7:0]  f;
    logic [16:0] wide;
    exp_t        r;
    case (t)
      LOGIC:            f = 8'h00;
      ARITHMETIC:       f = dr ? {8{d[7]}} : 8'h00;
      DOUBLE_PRECISION: f = c;
      default:          f = d;
    endcase
    if (!dr) begin
      wide    = {1'b0, d, f} << n;
      r.d     = wide[15:8];
      r.carry = wide[16];
    end else begin
      wide    = {f, d, 1'b0} >> n;
      r.d     = wide[8:1];
      r.carry = wide[0];
    end
    return r;
  endfunction

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Compare process: handshake signals are sampled on the falling edge, which
  // is what the following rising edge will act on.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (valid_o) begin
        if (sb_q.size() == 0) begin
          check_output("sb_unexpected_valid", 8'(valid_o), 8'd0);
        end else begin
          e = sb_q[0];
          check_output("sb_d_o", d_o, e.d);
          check_output("sb_carry_o", 8'(carry_o), 8'(e.carry));
          check_output("sb_zero_o", 8'(zero_o), 8'(e.d == 8'h00));
          if (ready_i) void'(sb_q.pop_front());
        end
      end
      if (valid_i && ready_o && !flush_i)
        sb_q.push_back(model(d_i, c_i, shift_size_i, shift_type_i, dir_i));
      if (flush_i) sb_q.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one operation and returns just after the edge that accepted it.
  task automatic apply_stimulus(input logic [7:0] d, input logic [7:0] c,
                                input logic [2:0] n, input logic [1:0] t,
                                input logic dr);
    int waited = 0;
    d_i = d; c_i = c; shift_size_i = n; shift_type_i = t; dir_i = dr;
    valid_i = 1'b1;
    @(negedge clk);
    while (!ready_o && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_o) check_output("send_timeout", 8'(ready_o), 8'd1);
    step();
    valid_i = 1'b0;
  endtask

  task automatic run_single(input string name, input logic [7:0] d, input logic [7:0] c,
                            input logic [2:0] n, input logic [1:0] t, input logic dr,
                            input logic [7:0] exp_d, input logic exp_c);
    int   waited = 0;
    exp_t m;
    m = model(d, c, n, t, dr);
    check_output({name, "_model_d"}, m.d, exp_d);
    check_output({name, "_model_c"}, 8'(m.carry), 8'(exp_c));
    apply_stimulus(d, c, n, t, dr);
    do begin
      step();
      waited++;
    end while (!valid_o && waited < 20);
    check_output({name, "_valid"}, 8'(valid_o), 8'd1);
    check_output({name, "_d_o"}, d_o, exp_d);
    check_output({name, "_carry"}, 8'(carry_o), 8'(exp_c));
    check_output({name, "_zero"}, 8'(zero_o), 8'(exp_d == 8'h00));
  endtask

  task automatic wait_drain(input string name);
    int waited = 0;
    while ((sb_q.size() != 0 || valid_o) && waited < 500) begin
      step();
      waited++;
    end
    check_output(name, 8'(sb_q.size()), 8'd0);
  endtask

  logic [7:0] held;
  bit         sender_done;
  bit         rand_done;
  int         gaps;

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    d_i = '0; c_i = '0; shift_size_i = '0; shift_type_i = '0; dir_i = 1'b0;
    #3;
    check_output("reset_valid_o", 8'(valid_o), 8'd0);
    check_output("reset_d_o", d_o, 8'h00);
    check_output("reset_flags", {6'd0, carry_o, zero_o}, 8'd0);
    #9 rst_n = 1'b1;
    step();

    // Test 1: latency is exactly two cycles after the transfer.
    apply_stimulus(8'hB5, 8'h00, 3'd3, LOGIC, DIR_LEFT);
    check_output("t1_not_yet_valid", 8'(valid_o), 8'd0);
    step();
    check_output("t1_valid", 8'(valid_o), 8'd1);
    check_output("t1_d_o", d_o, 8'hA8);
    check_output("t1_carry", 8'(carry_o), 8'd1);
    check_output("t1_zero", 8'(zero_o), 8'd0);

    // Tests 2 and 3: hand-computed results for each fill mode.
    run_single("t2_arith_r", 8'h96, 8'h00, 3'd2, ARITHMETIC, DIR_RIGHT, 8'hE5, 1'b1);
    run_single("t2_cyc_r", 8'h81, 8'h00, 3'd1, CYCLIC, DIR_RIGHT, 8'hC0, 1'b1);
    run_single("t3_dp_l", 8'h0F, 8'hA0, 3'd4, DOUBLE_PRECISION, DIR_LEFT, 8'hFA, 1'b0);
    run_single("t3_zero", 8'h80, 8'h00, 3'd1, LOGIC, DIR_LEFT, 8'h00, 1'b1);
    wait_drain("t3_drain");

    // Test 4: six back-to-back ops with a five-cycle consumer stall.
    sender_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          apply_stimulus(8'($urandom), 8'($urandom), 3'($urandom_range(1, 7)),
                         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        sender_done = 1'b1;
      end
      begin
        step();
        step();
        ready_i = 1'b0;
        #1;
        check_output("t4_ready_o_falls", 8'(ready_o), 8'd0);
        held = d_o;
        for (int s = 0; s < 5; s++) begin
          step();
          check_output("t4_stall_valid", 8'(valid_o), 8'd1);
          check_output("t4_stall_hold", d_o, held);
          check_output("t4_stall_ready_o", 8'(ready_o), 8'd0);
        end
        ready_i = 1'b1;
        gaps = 0;
        for (int t = 0; t < 100 && (sb_q.size() > 0 || !sender_done); t++) begin
          @(negedge clk);
          if (sb_q.size() > 0 && !valid_o) gaps++;
        end
        check_output("t4_no_gaps", 8'(gaps), 8'd0);
      end
    join
    wait_drain("t4_drain");

    // Test 5: zero shift is the identity for every type and direction.
    for (int t = 0; t < 4; t++)
      for (int dr = 0; dr < 2; dr++)
        run_single("t5_n0", 8'h5A, 8'hC3, 3'd0, 2'(t), 1'(dr), 8'h5A, 1'b0);
    wait_drain("t5_drain");

    // Test 6a: asynchronous reset with two operations in flight.
    apply_stimulus(8'h12, 8'h00, 3'd2, LOGIC, DIR_LEFT);
    apply_stimulus(8'h34, 8'h00, 3'd1, CYCLIC, DIR_RIGHT);
    #2 rst_n = 1'b0;
    #1;
    check_output("t6_rst_valid_o", 8'(valid_o), 8'd0);
    check_output("t6_rst_d_o", d_o, 8'h00);
    check_output("t6_rst_flags", {6'd0, carry_o, zero_o}, 8'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      check_output("t6_rst_idle", 8'(valid_o), 8'd0);
    end

    // Test 6b: flush with ops in flight; the op accepted in the flush cycle is dropped.
    apply_stimulus(8'h21, 8'h00, 3'd1, LOGIC, DIR_LEFT);
    apply_stimulus(8'h43, 8'h00, 3'd2, LOGIC, DIR_RIGHT);
    flush_i = 1'b1;
    #1;
    check_output("t6_flush_ready_o", 8'(ready_o), 8'd1);
    apply_stimulus(8'h65, 8'h00, 3'd3, CYCLIC, DIR_LEFT);
    flush_i = 1'b0;
    check_output("t6_flush_valid_o", 8'(valid_o), 8'd0);
    for (int s = 0; s < 4; s++) begin
      step();
      check_output("t6_flush_idle", 8'(valid_o), 8'd0);
    end

    // Scoreboard phase: random operations and random consumer back-pressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) step();
          apply_stimulus(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          step();
          ready_i = ($urandom_range(0, 9) < 7);
        end
        ready_i = 1'b1;
      end
    join
    wait_drain("random_drain");

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
